// File: rtl/bram_tdp.sv
// bram_tdp -- true dual-port synchronous block RAM.
//
// Two symmetric ports (A, B) share one memory array on a single clock. Each
// port reads and writes with per-byte write enables, has its own
// read-during-write mode, an optional second output register stage, and a
// read-valid flag that follows the data through the pipeline. A cross-port
// same-address access involving a write raises collision for one cycle.
//
// Ports:
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset (pipeline/flags only)
//   a_en / b_en         port enable
//   a_we / b_we         byte write enables, lane i = bits [i*BYTE_W +: BYTE_W]
//   a_addr / b_addr     word address (wraps modulo 2**ADDR_W)
//   a_write / b_write   write data
//   a_read / b_read     read data (latency 1, or 2 with OUT_REG=1)
//   a_valid / b_valid   read data belongs to an accepted read
//   collision           cross-port conflict accepted on the previous edge
//
// Read-during-write modes: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.

module bram_tdp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int BYTE_W  = 8,
    parameter int MODE_A  = 0,
    parameter int MODE_B  = 0,
    parameter int OUT_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_en,
    input  logic [DATA_W/BYTE_W-1:0]   a_we,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_write,
    output logic [DATA_W-1:0]          a_read,
    output logic                       a_valid,
    input  logic                       b_en,
    input  logic [DATA_W/BYTE_W-1:0]   b_we,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_write,
    output logic [DATA_W-1:0]          b_read,
    output logic                       b_valid,
    output logic                       collision
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
        $fatal(1, "bram_tdp: DATA_W must be a multiple of BYTE_W");
    end
    if (MODE_A < 0 || MODE_A > 2 || MODE_B < 0 || MODE_B > 2) begin : g_bad_mode
        $fatal(1, "bram_tdp: MODE_A/MODE_B must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_a_acc, w_b_acc;
    logic              w_a_wr, w_b_wr;
    logic              w_a_issue, w_b_issue;
    logic              w_coll;
    logic [DATA_W-1:0] w_a_old, w_b_old;
    logic [DATA_W-1:0] w_a_rd_next, w_b_rd_next;

    logic [DATA_W-1:0] r_a_rd1, r_b_rd1;
    logic              r_a_v1, r_b_v1;
    logic              r_coll;

    // Old word with the written lanes replaced by new data.
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     we);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) m[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        end
        return m;
    endfunction

    // A port only acts while out of reset; this also suppresses writes on
    // edges that arrive with rst_n low.
    assign w_a_acc = a_en & rst_n;
    assign w_b_acc = b_en & rst_n;
    assign w_a_wr  = w_a_acc & (|a_we);
    assign w_b_wr  = w_b_acc & (|b_we);

    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    // NO_CHANGE skips the read on a write cycle: register holds, valid drops.
    assign w_a_issue = w_a_acc & ~(w_a_wr & (MODE_A == 2));
    assign w_b_issue = w_b_acc & ~(w_b_wr & (MODE_B == 2));

    // WRITE_FIRST sees only its own port's write; the other port's write to
    // the same address is always read-first from this port's view.
    assign w_a_rd_next = (w_a_wr && MODE_A == 1) ? f_merge(w_a_old, a_write, a_we) : w_a_old;
    assign w_b_rd_next = (w_b_wr && MODE_B == 1) ? f_merge(w_b_old, b_write, b_we) : w_b_old;

    assign w_coll = w_a_acc & w_b_acc & (a_addr == b_addr) & (w_a_wr | w_b_wr);

    // NOTE: the array has no reset so it maps onto block RAM; contents
    // survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            // NOTE: non-blocking updates to the same lane take the last one
            // scheduled, so placing port A after port B makes A win overlaps.
            if (w_b_wr && b_we[i]) r_mem[b_addr][i*BYTE_W +: BYTE_W] <= b_write[i*BYTE_W +: BYTE_W];
            if (w_a_wr && a_we[i]) r_mem[a_addr][i*BYTE_W +: BYTE_W] <= a_write[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rd1 <= '0;
            r_b_rd1 <= '0;
            r_a_v1  <= 1'b0;
            r_b_v1  <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_a_v1 <= w_a_issue;
            r_b_v1 <= w_b_issue;
            if (w_a_issue) r_a_rd1 <= w_a_rd_next;
            if (w_b_issue) r_b_rd1 <= w_b_rd_next;
            r_coll <= w_coll;
        end
    end

    assign collision = r_coll;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_a_rd2, r_b_rd2;
        logic              r_a_v2, r_b_v2;

        // Second stage always advances; a bubble carries its held data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_rd2 <= '0;
                r_b_rd2 <= '0;
                r_a_v2  <= 1'b0;
                r_b_v2  <= 1'b0;
            end else begin
                r_a_rd2 <= r_a_rd1;
                r_b_rd2 <= r_b_rd1;
                r_a_v2  <= r_a_v1;
                r_b_v2  <= r_b_v1;
            end
        end

        assign a_read  = r_a_rd2;
        assign b_read  = r_b_rd2;
        assign a_valid = r_a_v2;
        assign b_valid = r_b_v2;
    end else begin : g_no_out_reg
        assign a_read  = r_a_rd1;
        assign b_read  = r_b_rd1;
        assign a_valid = r_a_v1;
        assign b_valid = r_b_v1;
    end

endmodule

// File: tb/tb_bram_tdp.sv
// tb_bram_tdp -- self-checking bench for bram_tdp.
//
// Three instances with different mode / output-register settings share one
// stimulus stream. A behavioural reference (word array plus a per-port history
// of read results) predicts every output after every edge.

`timescale 1ns/1ps

module tb_bram_tdp;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 8;
    localparam int NB = DW / BW;
    localparam int NI = 3;

    // Per-instance settings, matching the instantiations below.
    localparam int MA   [NI] = '{0, 1, 2};
    localparam int MB   [NI] = '{1, 2, 0};
    localparam int OUTR [NI] = '{0, 1, 0};

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          a_en, b_en;
    logic [NB-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_write, b_write;

    logic [DW-1:0] a_read [NI];
    logic [DW-1:0] b_read [NI];
    logic          a_valid [NI];
    logic          b_valid [NI];
    logic          collision [NI];

    always #5 clk = ~clk;

    bram_tdp #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .MODE_A(0), .MODE_B(1), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(a_read[0]), .a_valid(a_valid[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(b_read[0]), .b_valid(b_valid[0]),
        .collision(collision[0])
    );

    bram_tdp #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .MODE_A(1), .MODE_B(2), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(a_read[1]), .a_valid(a_valid[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(b_read[1]), .b_valid(b_valid[1]),
        .collision(collision[1])
    );

    bram_tdp #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .MODE_A(2), .MODE_B(0), .OUT_REG(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(a_read[2]), .a_valid(a_valid[2]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(b_read[2]), .b_valid(b_valid[2]),
        .collision(collision[2])
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl_mem [1 << AW];
    res_t          hist [NI][2][$];   // newest read result at the back
    logic          exp_coll;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] we);
        logic [DW-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) m[i*BW +: BW] = new_w[i*BW +: BW];
        end
        return m;
    endfunction

    // What one port returns for one edge, given its mode.
    function automatic res_t port_result(input int mode, input logic en, input logic wr,
                                         input logic [DW-1:0] old_w, input logic [DW-1:0] wd,
                                         input logic [NB-1:0] we, input res_t prev);
        res_t r;
        r.v = 1'b0;
        r.d = prev.d;
        if (en && !(wr && mode == 2)) begin
            r.v = 1'b1;
            r.d = (wr && mode == 1) ? merge(old_w, wd, we) : old_w;
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                hist[k][p].delete();
                hist[k][p].push_back('0);
                hist[k][p].push_back('0);
            end
        end
        exp_coll = 1'b0;
    endfunction

    function automatic void push_hist(input int k, input int p, input res_t r);
        hist[k][p].push_back(r);
        if (hist[k][p].size() > 4) void'(hist[k][p].pop_front());
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] old_a, old_b;
        logic          a_wr, b_wr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_a = mdl_mem[a_addr];
        old_b = mdl_mem[b_addr];
        a_wr  = a_en && (a_we != '0);
        b_wr  = b_en && (b_we != '0);
        for (int k = 0; k < NI; k++) begin
            push_hist(k, 0, port_result(MA[k], a_en, a_wr, old_a, a_write, a_we, hist[k][0][$]));
            push_hist(k, 1, port_result(MB[k], b_en, b_wr, old_b, b_write, b_we, hist[k][1][$]));
        end
        exp_coll = a_en && b_en && (a_addr == b_addr) && (a_wr || b_wr);
        // Port A applied last so it wins lanes both ports write.
        if (b_wr) mdl_mem[b_addr] = merge(mdl_mem[b_addr], b_write, b_we);
        if (a_wr) mdl_mem[a_addr] = merge(mdl_mem[a_addr], a_write, a_we);
    endfunction

    task automatic compare_all();
        res_t ea, eb;
        for (int k = 0; k < NI; k++) begin
            ea = hist[k][0][hist[k][0].size() - 1 - OUTR[k]];
            eb = hist[k][1][hist[k][1].size() - 1 - OUTR[k]];
            check($sformatf("u%0d.a_read", k),  a_read[k], ea.d);
            check($sformatf("u%0d.a_valid", k), 32'(a_valid[k]), 32'(ea.v));
            check($sformatf("u%0d.b_read", k),  b_read[k], eb.d);
            check($sformatf("u%0d.b_valid", k), 32'(b_valid[k]), 32'(eb.v));
            check($sformatf("u%0d.collision", k), 32'(collision[k]), 32'(exp_coll));
        end
    endtask

    // Drive one cycle of inputs, let an edge happen, then compare.
    task automatic step(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                        input logic be, input logic [NB-1:0] bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        a_en = ae; a_we = awe; a_addr = aad; a_write = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_write = bwd;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd_a(input logic [AW-1:0] aad);
        step(1'b1, '0, aad, '0, 1'b0, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    logic [AW-1:0] pool [16];
    logic [DW-1:0] init_a [8];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic          ae, be;
        logic [NB-1:0] awe, bwe;
        logic [AW-1:0] aad, bad;
        logic [DW-1:0] awd, bwd;
        int            exp_v [6];

        rst_n = 1'b1;
        a_en = 1'b0; a_we = '0; a_addr = '0; a_write = '0;
        b_en = 1'b0; b_we = '0; b_addr = '0; b_write = '0;
        model_reset();
        for (int i = 0; i < 16; i++) pool[i] = (i < 8) ? AW'(i) : AW'(10'h3F0 + i);

        // Reset held: every output must be zero.
        #2 rst_n = 1'b0;
        idle();
        idle();
        check("rst.a_read",    a_read[0], 32'h0);
        check("rst.a_valid",   32'(a_valid[0]), 32'h0);
        check("rst.collision", 32'(collision[0]), 32'h0);
        rst_n = 1'b1;

        // Single write on A, read back on B.
        step(1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        step(1'b0, '0, '0, '0, 1'b1, '0, 10'h005, '0);
        check("t1.b_read",  b_read[0], 32'hDEADBEEF);
        check("t1.b_valid", 32'(b_valid[0]), 32'h1);

        // Preload a small address pool plus the fixed test words.
        for (int i = 0; i < 8; i++) begin
            init_a[i] = $urandom;
            step(1'b1, 4'hF, pool[i], init_a[i], 1'b1, 4'hF, pool[i+8], $urandom);
        end
        step(1'b1, 4'hF, 10'h010, 32'h11223344, 1'b1, 4'hF, 10'h020, 32'hCAFEF00D);

        // Byte lanes: READ_FIRST (u0) sees old word, WRITE_FIRST (u1) merged.
        step(1'b1, 4'b0101, 10'h010, 32'hAABBCCDD, 1'b0, '0, '0, '0);
        check("rf.a_read", a_read[0], 32'h11223344);
        rd_a(10'h010);
        check("wf.a_read",    a_read[1], 32'h11BB33DD);
        check("lanes.a_read", a_read[0], 32'h11BB33DD);

        // READ_FIRST on a zero word and NO_CHANGE holding its last read.
        step(1'b1, 4'hF, 10'h031, 32'h12345678, 1'b1, 4'hF, 10'h030, 32'h0);
        rd_a(10'h031);
        check("nc.pre_read", a_read[2], 32'h12345678);
        step(1'b1, 4'hF, 10'h030, 32'h00000055, 1'b0, '0, '0, '0);
        check("rf0.a_read",  a_read[0], 32'h0);
        check("nc.a_read",   a_read[2], 32'h12345678);
        check("nc.a_valid",  32'(a_valid[2]), 32'h0);

        // Cross-port write/write at the top address: A wins, one-cycle flag.
        step(1'b1, 4'hF, 10'h3FF, 32'h0, 1'b0, '0, '0, '0);
        step(1'b1, 4'hF, 10'h3FF, 32'hFFFFFFFF, 1'b1, 4'hF, 10'h3FF, 32'h0);
        check("ww.collision", 32'(collision[0]), 32'h1);
        idle();
        check("ww.coll_clear", 32'(collision[0]), 32'h0);
        rd_a(10'h3FF);
        check("ww.a_read", a_read[0], 32'hFFFFFFFF);
        // A reads while B writes the same word.
        step(1'b1, '0, 10'h3FF, '0, 1'b1, 4'hF, 10'h3FF, 32'h0BADC0DE);
        check("rw.a_read",    a_read[0], 32'hFFFFFFFF);
        check("rw.collision", 32'(collision[0]), 32'h1);

        // Output-register pipeline with one bubble (u1, latency 2).
        idle();
        exp_v = '{0, 1, 1, 1, 0, 1};
        rd_a(pool[0]); check("pipe.v0", 32'(a_valid[1]), 32'(exp_v[0]));
        rd_a(pool[1]); check("pipe.v1", 32'(a_valid[1]), 32'(exp_v[1]));
        check("pipe.d0", a_read[1], init_a[0]);
        rd_a(pool[2]); check("pipe.v2", 32'(a_valid[1]), 32'(exp_v[2]));
        check("pipe.d1", a_read[1], init_a[1]);
        idle();        check("pipe.v3", 32'(a_valid[1]), 32'(exp_v[3]));
        check("pipe.d2", a_read[1], init_a[2]);
        rd_a(pool[3]); check("pipe.v4", 32'(a_valid[1]), 32'(exp_v[4]));
        check("pipe.hold", a_read[1], init_a[2]);
        idle();        check("pipe.v5", 32'(a_valid[1]), 32'(exp_v[5]));
        check("pipe.d3", a_read[1], init_a[3]);

        // Randomised traffic over the pool, frequently colliding.
        for (int n = 0; n < 400; n++) begin
            ae  = ($urandom_range(0, 3) != 0);
            be  = ($urandom_range(0, 3) != 0);
            awe = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
            bwe = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
            aad = pool[$urandom_range(0, 15)];
            bad = ($urandom_range(0, 2) == 0) ? aad : pool[$urandom_range(0, 15)];
            awd = $urandom;
            bwd = $urandom;
            step(ae, awe, aad, awd, be, bwe, bad, bwd);
        end

        // Asynchronous reset while a write to 0x020 is being presented.
        a_en = 1'b1; a_we = 4'hF; a_addr = 10'h020; a_write = 32'hDEAD0020;
        b_en = 1'b0; b_we = '0;   b_addr = '0;      b_write = '0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.a_read",    a_read[0], 32'h0);
        check("arst.a_valid",   32'(a_valid[0]), 32'h0);
        check("arst.b_read",    b_read[1], 32'h0);
        check("arst.b_valid",   32'(b_valid[1]), 32'h0);
        check("arst.collision", 32'(collision[0]), 32'h0);
        step(1'b1, 4'hF, 10'h020, 32'hDEAD0020, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        rd_a(10'h020);
        check("arst.kept",     a_read[0], 32'hCAFEF00D);
        check("arst.kept_vld", 32'(a_valid[0]), 32'h1);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_tdp.md
# bram_tdp

Parametrised true dual-port block RAM, the successor to the current single-write FIFO buffer RAM. Both ports read and write with per-byte write enables, a per-port read-during-write mode, an optional output pipeline register, read-valid tracking and a cross-port collision flag. It sits under FIFO, line-buffer and mailbox logic as the common synchronous memory primitive. It maps onto vendor BRAM inference.

## Interface
- DATA_W, 32: word width; must be a multiple of BYTE_W
- ADDR_W, 10: address width; depth = 2**ADDR_W
- BYTE_W, 8: write-enable lane width; NB = DATA_W/BYTE_W lanes
- MODE_A, 0: port A read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- MODE_B, 0: port B read-during-write mode, same encoding
- OUT_REG, 0: 1 adds an output register stage to both ports

Ports:
- clk  in  1  single clock; all activity on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_en  in  1  port A enable
- a_we  in  NB  port A byte write enables, lane i = bits [i*BYTE_W +: BYTE_W]
- a_addr  in  ADDR_W  port A address
- a_write  in  DATA_W  port A write data
- a_read  out  DATA_W  port A read data
- a_valid  out  1  a_read holds data for an accepted read
- b_en, b_we, b_addr, b_write, b_read, b_valid: port B, identical to port A
- collision  out  1  a cross-port conflict was accepted; aligned with the 1-cycle read stage

## Operation
- Access: a port acts in a cycle only when its en=1 and rst_n=1. Write = en & |we. Lanes with we[i]=0 keep their stored bytes.
- en=0: no memory access, the read register holds its value, and the valid stage loads 0.
- Reads are issued on every enabled cycle. There is one exception: a write cycle in NO_CHANGE mode. That cycle does not update the read register, and valid loads 0.
- READ_FIRST: a read during a write returns the word as it was before the write.
- WRITE_FIRST: a read during a write returns the merged word. Written lanes carry the new data; unwritten lanes carry the old data.
- Cross-port, same address, both enabled:
  - If one port writes, the other port's read returns the old word (read-first across ports).
  - If both ports write, port A wins on every lane where both we bits are set. Other lanes take their data from whichever port enables them.
  - collision=1 on the next edge if at least one port writes. Read/read at the same address is not a collision.
- Memory contents are not initialised and not cleared by reset. Power-up contents are X.
- Address wrap: addresses are used modulo 2**ADDR_W, with no range checking.
- Elaboration check: DATA_W % BYTE_W != 0 or MODE_x > 2 is a fatal error.

## Timing
- Reset values: a_read=0, b_read=0, a_valid=0, b_valid=0, collision=0. These apply immediately on rst_n falling, asynchronously.
- Reset mid-operation: all pipeline stages and valids clear. Writes are suppressed while rst_n=0. The first accepted access is on the first rising edge with rst_n=1.
- OUT_REG=0: data and valid for an access at edge N are visible after edge N (latency 1).
- OUT_REG=1: data and valid are visible after edge N+1 (latency 2).
  - The second stage always advances and copies stage 1 data and valid. A bubble (valid=0) holds its data value and propagates valid=0.
- collision is always latency 1 and is cleared each cycle with no new conflict. It does not stick.
- Back-to-back accesses are accepted every cycle on both ports, with no stall and no backpressure.
- A write at edge N is readable by either port from an access at edge N+1.

## Test plan
- Reset, then a single write: DATA_W=32, OUT_REG=0. Hold rst_n=0 and check all outputs are 0. Write A addr 0x005 = 0xDEADBEEF, we=4'hF. Read B addr 0x005 on the next cycle -> b_read=0xDEADBEEF and b_valid=1 one cycle later.
- Byte lanes and WRITE_FIRST: addr 0x010 holds 0x11223344. Port A (MODE_A=1) writes 0xAABBCCDD with we=4'b0101 -> a_read=0x11BB33DD same cycle+1. A subsequent read returns 0x11BB33DD.
- Read-during-write modes:
  - READ_FIRST: old word 0x0 is returned.
  - NO_CHANGE: a_read keeps its prior value 0x12345678 and a_valid=0.
- Cross-port conflict: addr 0x3FF holds 0x0. A writes 0xFFFFFFFF and B writes 0x00000000, both we=4'hF, same cycle -> collision=1 for one cycle and the memory holds 0xFFFFFFFF.
- Separate case: A reads and B writes the same address -> a_read returns the old value and collision=1.
- OUT_REG=1 pipeline: read addr 0,1,2 on consecutive cycles. Data appears 2 cycles after each issue with valid=1,1,1. Inserting an en=0 cycle produces exactly one valid=0 bubble.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while a write to 0x020 is held. The outputs clear immediately and 0x020 keeps its old contents.
